// File: rtl/sandbox_host_link.sv
// Host-side link for the sandbox process. Host bytes are packed into words and handed over
// with a dataReceived/clearDR handshake. Result words go back to the host as a byte stream.
module sandbox_host_link #(
    parameter int unsigned WORD_BYTES = 6,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned RX_TIMEOUT = 0
) (
    input  logic                    masterClock,
    input  logic                    reset,
    input  logic                    rxByteValid,
    input  logic [7:0]              rxByte,
    output logic                    dataReceived,
    output logic [8*WORD_BYTES-1:0] inputData,
    input  logic                    clearDR,
    input  logic                    transmitData,
    input  logic [8*WORD_BYTES-1:0] outputData,
    output logic                    txByteValid,
    output logic [7:0]              txByte,
    input  logic                    txByteReady,
    output logic                    overrun
);

    localparam int unsigned W  = 8 * WORD_BYTES;
    localparam int unsigned CW = $clog2(WORD_BYTES + 1);
    localparam int unsigned TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((RX_TIMEOUT == 0) ? 0 : RX_TIMEOUT - 1);

    typedef enum logic [1:0] {R_COLLECT, R_PENDING, R_RELEASE} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAITLOW} tx_state_t;

    rx_state_t      rx_state_q;
    logic [CW-1:0]  rx_cnt_q;
    logic [TW-1:0]  rx_timer_q;
    logic [W-1:0]   rx_sh_q, rx_sh_d;
    logic [W-1:0]   in_data_q;
    logic           dr_q;
    logic           ovr_q;

    tx_state_t      tx_state_q;
    logic [CW-1:0]  tx_idx_q;
    logic [W-1:0]   tx_sh_q, tx_sh_d;
    logic           tx_valid_q;

    // The next byte always enters on the side that ends up last on the wire.
    always_comb begin
        rx_sh_d = '0;
        tx_sh_d = '0;
        if (MSB_FIRST) begin
            rx_sh_d = {rx_sh_q[W-9:0], rxByte};
            tx_sh_d = {tx_sh_q[W-9:0], 8'h00};
        end else begin
            rx_sh_d = {rxByte, rx_sh_q[W-1:8]};
            tx_sh_d = {8'h00, tx_sh_q[W-1:8]};
        end
    end

    always_ff @(posedge masterClock) begin
        if (reset) begin
            rx_state_q <= R_COLLECT;
            rx_cnt_q   <= '0;
            rx_timer_q <= '0;
            rx_sh_q    <= '0;
            in_data_q  <= '0;
            dr_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            case (rx_state_q)
                R_COLLECT: begin
                    if (rxByteValid) begin
                        rx_timer_q <= '0;
                        if (rx_cnt_q == LAST_IDX) begin
                            in_data_q  <= rx_sh_d;
                            dr_q       <= 1'b1;
                            rx_cnt_q   <= '0;
                            rx_sh_q    <= '0;
                            rx_state_q <= R_PENDING;
                        end else begin
                            rx_sh_q  <= rx_sh_d;
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end else if ((RX_TIMEOUT != 0) && (rx_cnt_q != '0)) begin
                        // A stalled partial word is silently dropped after RX_TIMEOUT idle cycles.
                        if (rx_timer_q == TMO_LAST) begin
                            rx_cnt_q   <= '0;
                            rx_timer_q <= '0;
                            rx_sh_q    <= '0;
                        end else begin
                            rx_timer_q <= rx_timer_q + 1'b1;
                        end
                    end
                end
                R_PENDING: begin
                    if (rxByteValid) ovr_q <= 1'b1;
                    if (clearDR) begin
                        dr_q       <= 1'b0;
                        rx_state_q <= R_RELEASE;
                    end
                end
                R_RELEASE: begin
                    if (rxByteValid) ovr_q <= 1'b1;
                    if (!clearDR) rx_state_q <= R_COLLECT;
                end
                default: rx_state_q <= R_COLLECT;
            endcase
        end
    end

    always_ff @(posedge masterClock) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (transmitData) begin
                        tx_sh_q    <= outputData;
                        tx_idx_q   <= '0;
                        tx_valid_q <= 1'b1;
                        tx_state_q <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (tx_valid_q && txByteReady) begin
                        tx_sh_q <= tx_sh_d;
                        if (tx_idx_q == LAST_IDX) begin
                            tx_valid_q <= 1'b0;
                            tx_state_q <= T_WAITLOW;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                        end
                    end
                end
                T_WAITLOW: begin
                    if (!transmitData) tx_state_q <= T_IDLE;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    assign dataReceived = dr_q;
    assign inputData    = in_data_q;
    assign overrun      = ovr_q;
    assign txByteValid  = tx_valid_q;
    assign txByte       = MSB_FIRST ? tx_sh_q[W-1 -: 8] : tx_sh_q[7:0];

endmodule

// File: tb/tb_sandbox_host_link.sv
// Directed bench for sandbox_host_link (MSB_FIRST=1, RX_TIMEOUT=16).
module tb_sandbox_host_link;

    logic        masterClock = 1'b0;
    logic        reset = 1'b1;
    logic        rxByteValid = 1'b0;
    logic [7:0]  rxByte = 8'h00;
    logic        dataReceived;
    logic [47:0] inputData;
    logic        clearDR = 1'b0;
    logic        transmitData = 1'b0;
    logic [47:0] outputData = '0;
    logic        txByteValid;
    logic [7:0]  txByte;
    logic        txByteReady = 1'b0;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    sandbox_host_link #(
        .WORD_BYTES (6),
        .MSB_FIRST  (1'b1),
        .RX_TIMEOUT (16)
    ) dut (
        .masterClock  (masterClock),
        .reset        (reset),
        .rxByteValid  (rxByteValid),
        .rxByte       (rxByte),
        .dataReceived (dataReceived),
        .inputData    (inputData),
        .clearDR      (clearDR),
        .transmitData (transmitData),
        .outputData   (outputData),
        .txByteValid  (txByteValid),
        .txByte       (txByte),
        .txByteReady  (txByteReady),
        .overrun      (overrun)
    );

    always #5 masterClock = ~masterClock;

    task automatic tick();
        @(posedge masterClock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxByteValid = 1'b1;
        rxByte      = b;
        tick();
        rxByteValid = 1'b0;
    endtask

    task automatic release_word();
        clearDR = 1'b1;
        tick();
        clearDR = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (dataReceived !== 1'b0) begin bad++; $display("FAIL reset_dr: got %b want 0", dataReceived); end
        total++; if (inputData !== 48'h0) begin bad++; $display("FAIL reset_data: got %h want 0", inputData); end
        total++; if (txByteValid !== 1'b0) begin bad++; $display("FAIL reset_txv: got %b want 0", txByteValid); end
        total++; if (txByte !== 8'h00) begin bad++; $display("FAIL reset_txb: got %h want 00", txByte); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    endtask

    task automatic test_timeout();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        repeat (20) tick();
        for (int i = 0; i < 3; i++) send_byte(8'h10 + 8'(i));
        total++; if (dataReceived !== 1'b0) begin bad++; $display("FAIL tmo_discard: got dr=%b want 0", dataReceived); end
        for (int i = 3; i < 6; i++) send_byte(8'h10 + 8'(i));
        total++; if (dataReceived !== 1'b1) begin bad++; $display("FAIL tmo_dr: got %b want 1", dataReceived); end
        total++; if (inputData !== 48'h101112131415) begin bad++; $display("FAIL tmo_data: got %h want 101112131415", inputData); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL tmo_ovr: got %b want 0", overrun); end
        release_word();
        // Byte landing on the would-be expiry cycle is accepted.
        send_byte(8'hA0); send_byte(8'hA1);
        repeat (15) tick();
        for (int i = 2; i < 6; i++) send_byte(8'hA0 + 8'(i));
        total++; if (dataReceived !== 1'b1 || inputData !== 48'hA0A1A2A3A4A5) begin
            bad++; $display("FAIL tmo_byte_wins: got dr=%b data=%h want 1 a0a1a2a3a4a5", dataReceived, inputData);
        end
        release_word();
    endtask

    task automatic test_rx_basic();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        total++; if (dataReceived !== 1'b0) begin bad++; $display("FAIL rx_early: got dr=%b want 0", dataReceived); end
        send_byte(8'h06);
        total++; if (dataReceived !== 1'b1) begin bad++; $display("FAIL rx_dr: got %b want 1", dataReceived); end
        total++; if (inputData !== 48'h010203040506) begin bad++; $display("FAIL rx_data: got %h want 010203040506", inputData); end
    endtask

    task automatic test_overrun();
        send_byte(8'hFF);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        total++; if (inputData !== 48'h010203040506) begin bad++; $display("FAIL ovr_data: got %h want 010203040506", inputData); end
        total++; if (dataReceived !== 1'b1) begin bad++; $display("FAIL ovr_dr: got %b want 1", dataReceived); end
    endtask

    task automatic test_clear();
        clearDR = 1'b1;
        tick();
        total++; if (dataReceived !== 1'b0) begin bad++; $display("FAIL clr_dr: got %b want 0", dataReceived); end
        send_byte(8'h77);
        clearDR = 1'b0;
        send_byte(8'h78);
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        total++; if (dataReceived !== 1'b0) begin bad++; $display("FAIL clr_drop: got dr=%b want 0", dataReceived); end
        send_byte(8'h25);
        total++; if (dataReceived !== 1'b1 || inputData !== 48'h202122232425) begin
            bad++; $display("FAIL clr_word: got dr=%b data=%h want 1 202122232425", dataReceived, inputData);
        end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL clr_ovr_sticky: got %b want 1", overrun); end
        release_word();
    endtask

    task automatic test_tx();
        logic [47:0] w;
        int k;
        int cyc;
        int resent;
        w = 48'hA1B2C3D4E5F6;
        outputData   = w;
        transmitData = 1'b1;
        tick();
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 200) begin
            total++; if (txByteValid !== 1'b1 || txByte !== w[47-8*k -: 8]) begin
                bad++; $display("FAIL tx_byte%0d: got v=%b b=%h want 1 %h", k, txByteValid, txByte, w[47-8*k -: 8]);
            end
            txByteReady = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (cyc == 1) outputData = 48'h0;
            tick();
            if (txByteReady) k++;
            cyc++;
        end
        txByteReady = 1'b0;
        total++; if (k != 6) begin bad++; $display("FAIL tx_budget: got %0d bytes want 6", k); end
        total++; if (txByteValid !== 1'b0) begin bad++; $display("FAIL tx_end: got v=%b want 0", txByteValid); end
        resent = 0;
        txByteReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (txByteValid !== 1'b0) resent++;
            tick();
        end
        total++; if (resent != 0) begin bad++; $display("FAIL tx_noresend: got %0d valid cycles want 0", resent); end
        txByteReady  = 1'b0;
        transmitData = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        outputData   = 48'h010203040506;
        transmitData = 1'b1;
        txByteReady  = 1'b1;
        tick();
        tick();
        tick();
        txByteReady = 1'b0;
        total++; if (txByteValid !== 1'b1 || txByte !== 8'h03) begin
            bad++; $display("FAIL mid_tx: got v=%b b=%h want 1 03", txByteValid, txByte);
        end
        send_byte(8'h90); send_byte(8'h91); send_byte(8'h92);
        reset = 1'b1;
        transmitData = 1'b0;
        tick();
        reset = 1'b0;
        total++; if (txByteValid !== 1'b0 || txByte !== 8'h00) begin
            bad++; $display("FAIL mid_rst_tx: got v=%b b=%h want 0 00", txByteValid, txByte);
        end
        total++; if (dataReceived !== 1'b0 || inputData !== 48'h0 || overrun !== 1'b0) begin
            bad++; $display("FAIL mid_rst_rx: got dr=%b data=%h ovr=%b want 0 0 0", dataReceived, inputData, overrun);
        end
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
        total++; if (dataReceived !== 1'b0) begin bad++; $display("FAIL mid_partial_lost: got dr=%b want 0", dataReceived); end
        for (int i = 3; i < 6; i++) send_byte(8'h40 + 8'(i));
        total++; if (dataReceived !== 1'b1 || inputData !== 48'h404142434445) begin
            bad++; $display("FAIL mid_newword: got dr=%b data=%h want 1 404142434445", dataReceived, inputData);
        end
        release_word();
    endtask

    task automatic test_back_to_back();
        logic [47:0] w;
        w = 48'h5A6B7C8D9EAF;
        outputData   = w;
        transmitData = 1'b1;
        txByteReady  = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            total++; if (txByteValid !== 1'b1 || txByte !== w[47-8*i -: 8]) begin
                bad++; $display("FAIL b2b_byte%0d: got v=%b b=%h want 1 %h", i, txByteValid, txByte, w[47-8*i -: 8]);
            end
            rxByteValid = 1'b1;
            rxByte      = 8'h30 + 8'(i);
            tick();
        end
        rxByteValid = 1'b0;
        txByteReady = 1'b0;
        total++; if (txByteValid !== 1'b0) begin bad++; $display("FAIL b2b_end: got v=%b want 0", txByteValid); end
        total++; if (dataReceived !== 1'b1 || inputData !== 48'h303132333435) begin
            bad++; $display("FAIL b2b_rx: got dr=%b data=%h want 1 303132333435", dataReceived, inputData);
        end
        transmitData = 1'b0;
        release_word();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_rx_basic();
        test_overrun();
        test_clear();
        test_tx();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
